commit_trace_serializer: RTL

- Synthesizable retire-trace capture for the multi-issue pipeline; generalises the bench-side per-lane write checking (memory, register and HI/LO writes) to LANES issue paths.
- Captures each cycle's retired side-effects into a packet FIFO, then serialises them into one ordered event stream with a valid/ready handshake for an on-chip comparator or debug UART.
- Sits beside the write-back stage.

---
 rtl/cpu_defs_pkg.sv | 21 ++
 rtl/trace_packet_fifo.sv | 48 ++++
 rtl/commit_trace_serializer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared retire-trace types.
// Event kinds, per-lane event count and the serialised event record.
package cpu_defs;

  typedef enum logic [1:0] {
    TRACE_MEM  = 2'd0,
    TRACE_REG  = 2'd1,
    TRACE_HILO = 2'd2
  } TraceKind_t;

  localparam int TRACE_EVENTS_PER_LANE = 3;

  typedef struct packed {
    TraceKind_t  kind;
    logic [1:0]  lane;
    logic [31:0] addr;
    logic [63:0] data;
    logic [31:0] cycle;
  } TraceEvent_t;

endpackage

// File: rtl/trace_packet_fifo.sv
// Generic synchronous FIFO, first-word fall-through read.
// A push into a full FIFO only lands when a pop frees a slot that cycle.
module trace_packet_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/commit_trace_serializer.sv
// Retire-trace capture: per-cycle packets into a FIFO, then one
// ordered valid/ready event stream (lane-major, mem/reg/hilo).
module commit_trace_serializer
  import cpu_defs::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 16,
  parameter int ADDR_W = 16,
  parameter int FILTER_ZERO = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr_ovf,
  input  logic [LANES-1:0]      reg_we,
  input  logic [LANES*5-1:0]    reg_waddr,
  input  logic [LANES*32-1:0]   reg_wdata,
  input  logic [LANES-1:0]      hilo_we,
  input  logic [LANES*64-1:0]   hilo,
  input  logic [LANES-1:0]      mem_we,
  input  logic [LANES*ADDR_W-1:0] mem_addr,
  input  logic [LANES*32-1:0]   mem_data,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [1:0]            ev_kind,
  output logic [1:0]            ev_lane,
  output logic [ADDR_W-1:0]     ev_addr,
  output logic [63:0]           ev_data,
  output logic [31:0]           ev_cycle,
  output logic                  stall_req,
  output logic                  overflow
);
  localparam int NB = TRACE_EVENTS_PER_LANE * LANES;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0]             cycle;
    logic [NB-1:0]           bits;
    logic [LANES*ADDR_W-1:0] maddr;
    logic [LANES*32-1:0]     mdata;
    logic [LANES*5-1:0]      raddr;
    logic [LANES*32-1:0]     rdata;
    logic [LANES*64-1:0]     hilo;
  } pkt_t;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t        state, state_n;
  pkt_t          in_pkt, head, hold;
  TraceEvent_t   ev;
  logic [31:0]   cyc;
  logic [NB-1:0] bits, low;
  logic [CW-1:0] count, count_n;
  logic          push, pop, full, empty;
  logic          acc, drop, fire, last;

  always_comb begin
    bits = '0;
    for (int l = 0; l < LANES; l++) begin
      bits[l*3]   = mem_we[l];
      bits[l*3+1] = reg_we[l] &
                    ((reg_waddr[l*5+:5] != 5'd0) | (FILTER_ZERO == 0));
      bits[l*3+2] = hilo_we[l];
    end
  end

  assign push   = en & (|bits);
  assign in_pkt = '{cycle: cyc, bits: bits, maddr: mem_addr,
                    mdata: mem_data, raddr: reg_waddr,
                    rdata: reg_wdata, hilo: hilo};

  trace_packet_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(pkt_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (in_pkt),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // hold.bits doubles as the pending mask; lowest set bit goes first
  assign low  = hold.bits & (~hold.bits + NB'(1));
  assign last = ((hold.bits & ~low) == '0);
  assign fire = ev_valid & ev_ready;

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        state_n = EMIT;
      end
      EMIT: if (fire && last) begin
        if (!empty) pop = 1'b1;
        else        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ev       = '0;
    ev.cycle = hold.cycle;
    for (int l = 0; l < LANES; l++) begin
      if (low[l*3]) begin
        ev.kind = TRACE_MEM;
        ev.lane = 2'(l);
        ev.addr = 32'(hold.maddr[l*ADDR_W+:ADDR_W]);
        ev.data = 64'(hold.mdata[l*32+:32]);
      end
      if (low[l*3+1]) begin
        ev.kind = TRACE_REG;
        ev.lane = 2'(l);
        ev.addr = 32'(hold.raddr[l*5+:5]);
        ev.data = 64'(hold.rdata[l*32+:32]);
      end
      if (low[l*3+2]) begin
        ev.kind = TRACE_HILO;
        ev.lane = 2'(l);
        ev.data = hold.hilo[l*64+:64];
      end
    end
  end

  assign ev_valid = (state == EMIT);
  assign ev_kind  = ev.kind;
  assign ev_lane  = ev.lane;
  assign ev_addr  = ADDR_W'(ev.addr);
  assign ev_data  = ev.data;
  assign ev_cycle = ev.cycle;

  assign acc     = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign count_n = count + CW'(acc) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold      <= '0;
      cyc       <= '0;
      overflow  <= 1'b0;
      stall_req <= 1'b0;
    end else begin
      state     <= state_n;
      cyc       <= cyc + 32'd1;
      stall_req <= (count_n >= CW'(DEPTH - 1));
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      if (pop)          hold <= head;
      else if (fire)    hold.bits <= hold.bits & ~low;
    end
  end

endmodule
